// File: rtl/pipe_pc_ifid.sv
// pipe_pc_ifid: PC register and IF/ID pipeline register with stall, flush, halt and perf counters
//   Optional feature: define PIPE_DELAY_SLOT_EN for a branch delay slot.
//   The instruction behind a control transfer then issues normally instead of
//   being squashed, and flush_cnt stays 0.
// Ports:
//   clock, reset          single clock; synchronous active-high reset
//   npc, pc4, ins         fetch-stage next pc, pc+4 and the instruction read at pc
//   pcsource              00 seq, 01 branch, 10 jr, 11 j/jal (from ID)
//   wpcir                 1 advances pc and IF/ID, 0 stalls both
//   halt_req              level request to freeze fetch
//   pc                    current fetch address
//   dpc4, inst, dvalid    IF/ID contents; dvalid=0 marks an injected bubble
//   halted                high while in HALT
//   stall_cnt, flush_cnt  saturating performance counters
module pipe_pc_ifid #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      npc,
  input  logic [31:0]      pc4,
  input  logic [31:0]      ins,
  input  logic [1:0]       pcsource,
  input  logic             wpcir,
  input  logic             halt_req,
  output logic [31:0]      pc,
  output logic [31:0]      dpc4,
  output logic [31:0]      inst,
  output logic             dvalid,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
`ifdef PIPE_DELAY_SLOT_EN
  localparam logic SQUASH = 1'b0;
`else
  localparam logic SQUASH = 1'b1;
`endif
  typedef enum logic {RUN, HALT} state_t;
  state_t           r_state, w_next;
  logic [31:0]      r_pc, r_dpc4, r_inst;
  logic             r_dvalid;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_run, w_halt, w_stall, w_adv, w_flush;
  // a halt request only takes effect on an edge that would otherwise advance,
  // so a stalled ID instruction is never lost
  always_comb begin
    w_run   = r_state == RUN;
    w_stall = w_run && !wpcir;
    w_halt  = w_run && wpcir && halt_req;
    w_adv   = w_run && wpcir && !halt_req;
    w_flush = w_adv && pcsource != 2'b00 && SQUASH;
    w_next  = w_halt ? HALT : r_state;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= RUN;
      r_pc        <= RESET_PC;
      r_dpc4      <= 32'h0;
      r_inst      <= NOP_INST;
      r_dvalid    <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_halt) begin
        r_inst   <= NOP_INST;
        r_dvalid <= 1'b0;
      end
      if (w_adv) begin
        r_pc     <= npc;
        r_dpc4   <= pc4;
        r_inst   <= w_flush ? NOP_INST : ins;
        r_dvalid <= !w_flush;
      end
      if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end
  assign pc        = r_pc;
  assign dpc4      = r_dpc4;
  assign inst      = r_inst;
  assign dvalid    = r_dvalid;
  assign halted    = r_state == HALT;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_pipe_pc_ifid.sv
// tb_pipe_pc_ifid: randomized and directed check of pipe_pc_ifid against a behavioural model
module tb_pipe_pc_ifid;
  logic        clock = 1'b0;
  logic        reset, wpcir, halt_req;
  logic [31:0] npc, pc4, ins;
  logic [1:0]  pcsource;
  logic [31:0] pc, dpc4, inst;
  logic        dvalid, halted;
  logic [15:0] stall_cnt, flush_cnt;
  int          total = 0, bad = 0;
  logic [31:0] m_pc, m_dpc4, m_inst;
  logic        m_dv, m_halt;
  int          m_sc, m_fc;
`ifdef PIPE_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif
  pipe_pc_ifid dut (
    .clock(clock), .reset(reset), .npc(npc), .pc4(pc4), .ins(ins),
    .pcsource(pcsource), .wpcir(wpcir), .halt_req(halt_req),
    .pc(pc), .dpc4(dpc4), .inst(inst), .dvalid(dvalid), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model();
    if (reset) begin
      m_pc = 32'h0; m_dpc4 = 32'h0; m_inst = 32'h0; m_dv = 1'b0; m_halt = 1'b0; m_sc = 0; m_fc = 0;
    end else if (!m_halt) begin
      if (!wpcir) begin
        if (m_sc < 65535) m_sc++;
      end else if (halt_req) begin
        m_halt = 1'b1; m_inst = 32'h0; m_dv = 1'b0;
      end else begin
        m_pc = npc; m_dpc4 = pc4;
        if (pcsource != 2'b00 && !DS) begin
          m_inst = 32'h0; m_dv = 1'b0;
          if (m_fc < 65535) m_fc++;
        end else begin
          m_inst = ins; m_dv = 1'b1;
        end
      end
    end
  endtask
  task automatic step(input logic r, input logic [31:0] n, input logic [31:0] p4, input logic [31:0] i,
                      input logic [1:0] ps, input logic w, input logic h, input bit full);
    reset = r; npc = n; pc4 = p4; ins = i; pcsource = ps; wpcir = w; halt_req = h;
    @(posedge clock);
    model();
    #1;
    if (full) begin
      check("pc", pc, m_pc);
      check("dpc4", dpc4, m_dpc4);
      check("inst", inst, m_inst);
      check("dvalid", {31'h0, dvalid}, {31'h0, m_dv});
      check("halted", {31'h0, halted}, {31'h0, m_halt});
      check("stall_cnt", {16'h0, stall_cnt}, m_sc);
      check("flush_cnt", {16'h0, flush_cnt}, m_fc);
    end
  endtask
  task automatic seq();
    step(1'b0, m_pc + 4, m_pc + 4, $urandom, 2'b00, 1'b1, 1'b0, 1'b1);
  endtask
  initial begin
    step(1'b1, 32'h0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1);
    check("rst_pc", pc, 32'h0);
    check("rst_dvalid", {31'h0, dvalid}, 32'h0);
    seq(); seq(); seq();
    check("t1_pc", pc, 32'd12);
    check("t1_dpc4", dpc4, 32'd12);
    step(1'b0, $urandom, $urandom, $urandom, 2'b01, 1'b0, 1'b0, 1'b1);
    step(1'b0, $urandom, $urandom, $urandom, 2'b00, 1'b0, 1'b1, 1'b1);
    check("t2_pc", pc, 32'd12);
    check("t2_stall", {16'h0, stall_cnt}, 32'd2);
    step(1'b0, 32'h40, 32'h10, 32'h8C010004, 2'b01, 1'b1, 1'b0, 1'b1);
    check("t3_pc", pc, 32'h40);
    check("t3_inst", inst, DS ? 32'h8C010004 : 32'h0);
    check("t3_flush", {16'h0, flush_cnt}, DS ? 32'd0 : 32'd1);
    step(1'b0, 32'h100, 32'h44, $urandom, 2'b10, 1'b0, 1'b0, 1'b1);
    check("t4_pc", pc, 32'h40);
    check("t4_stall", {16'h0, stall_cnt}, 32'd3);
    seq();
    step(1'b0, 32'h200, 32'h4C, $urandom, 2'b11, 1'b1, 1'b1, 1'b1);
    check("t5_halted", {31'h0, halted}, 32'h1);
    check("t5_pc", pc, 32'h44);
    for (int k = 0; k < 10; k++)
      step(1'b0, $urandom, $urandom, $urandom, 2'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    check("t5_hold_pc", pc, 32'h44);
    step(1'b1, $urandom, $urandom, $urandom, 2'b00, 1'b1, 1'b0, 1'b1);
    check("t5_reset_halted", {31'h0, halted}, 32'h0);
    for (int k = 0; k < 65537; k++)
      step(1'b0, $urandom, $urandom, $urandom, 2'($urandom), 1'b0, 1'($urandom), k >= 65530);
    check("t6_sat", {16'h0, stall_cnt}, 32'hFFFF);
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 99) == 0, $urandom, $urandom, $urandom, 2'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
